// File: rtl/decode_stage.sv
// decode_stage: IF/ID pipeline register, RV32I control/immediate decode and
// a 32x32 register file with write-through bypass from the Writeback stage.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [31:0] InstrF,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        RegWriteD,
  output logic        MemWriteD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic [1:0]  ResultSrcD,
  output logic [2:0]  ALUControlD
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_e;

  logic [31:0] instr_q, pc_q, pcp4_q;
  logic [31:0] rf_q [32];
  logic        wb_active;
  imm_sel_e    imm_sel;
  logic        alu_by_funct3;
  logic        sub_allowed;

  // IF/ID register: reset and flush both inject a NOP, flush beats stall
  always_ff @(posedge clk) begin
    if (rst || FlushD) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC;
      pcp4_q  <= RESET_PC;
    end else if (!StallD) begin
      instr_q <= InstrF;
      pc_q    <= PCF;
      pcp4_q  <= PCPlus4F;
    end
  end

  // Register file write port; x0 is never written so it stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_q[RdW] <= ResultW;
    end
  end

  assign Rs1D     = instr_q[19:15];
  assign Rs2D     = instr_q[24:20];
  assign RdD      = instr_q[11:7];
  assign PCD      = pc_q;
  assign PCPlus4D = pcp4_q;

  // A write landing this cycle is forwarded so decode never sees stale data
  assign wb_active = RegWriteW && (RdW != 5'd0);
  assign RD1D = (wb_active && (RdW == Rs1D)) ? ResultW :
                (Rs1D == 5'd0) ? 32'd0 : rf_q[Rs1D];
  assign RD2D = (wb_active && (RdW == Rs2D)) ? ResultW :
                (Rs2D == 5'd0) ? 32'd0 : rf_q[Rs2D];

  // Main control decode from the opcode
  always_comb begin
    RegWriteD     = 1'b0;
    MemWriteD     = 1'b0;
    JumpD         = 1'b0;
    BranchD       = 1'b0;
    ALUSrcD       = 1'b0;
    ResultSrcD    = 2'b00;
    imm_sel       = IMM_NONE;
    alu_by_funct3 = 1'b0;
    sub_allowed   = 1'b0;
    case (instr_q[6:0])
      OP_LW: begin
        RegWriteD  = 1'b1;
        ALUSrcD    = 1'b1;
        ResultSrcD = 2'b01;
        imm_sel    = IMM_I;
      end
      OP_SW: begin
        MemWriteD = 1'b1;
        ALUSrcD   = 1'b1;
        imm_sel   = IMM_S;
      end
      OP_R: begin
        RegWriteD     = 1'b1;
        alu_by_funct3 = 1'b1;
        sub_allowed   = 1'b1;
      end
      OP_IALU: begin
        RegWriteD     = 1'b1;
        ALUSrcD       = 1'b1;
        imm_sel       = IMM_I;
        alu_by_funct3 = 1'b1;
      end
      OP_BEQ: begin
        BranchD = 1'b1;
        imm_sel = IMM_B;
      end
      OP_JAL: begin
        JumpD      = 1'b1;
        RegWriteD  = 1'b1;
        ResultSrcD = 2'b10;
        imm_sel    = IMM_J;
      end
      default: ;
    endcase
  end

  // ALU operation select; only R-type may turn funct3=000 into a subtract
  always_comb begin
    ALUControlD = ALU_ADD;
    if (BranchD) begin
      ALUControlD = ALU_SUB;
    end else if (alu_by_funct3) begin
      case (instr_q[14:12])
        3'b000:  ALUControlD = (sub_allowed && instr_q[30]) ? ALU_SUB : ALU_ADD;
        3'b010:  ALUControlD = ALU_SLT;
        3'b100:  ALUControlD = ALU_XOR;
        3'b110:  ALUControlD = ALU_OR;
        3'b111:  ALUControlD = ALU_AND;
        default: ALUControlD = ALU_ADD;
      endcase
    end
  end

  // Immediate extraction, sign-extended from bit 31
  always_comb begin
    ImmExtD = 32'd0;
    case (imm_sel)
      IMM_I:   ImmExtD = {{20{instr_q[31]}}, instr_q[31:20]};
      IMM_S:   ImmExtD = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      IMM_B:   ImmExtD = {{20{instr_q[31]}}, instr_q[7], instr_q[30:25],
                          instr_q[11:8], 1'b0};
      IMM_J:   ImmExtD = {{12{instr_q[31]}}, instr_q[19:12], instr_q[20],
                          instr_q[30:21], 1'b0};
      default: ImmExtD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus randomized traffic
// checked against an arithmetic reference model of the stage.
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        rst, StallD, FlushD;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pcp4;
    logic        regw, memw, jump, branch, alusrc;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
  } out_t;

  // reference model state
  logic [31:0] m_instr, m_pc, m_pcp4;
  logic [31:0] m_rf [32];

  decode_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int imm_i(logic [31:0] ins);
    int v = int'(ins[31:20]);
    if (ins[31]) v -= 4096;
    return v;
  endfunction

  function automatic int imm_s(logic [31:0] ins);
    int v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
    if (ins[31]) v -= 4096;
    return v;
  endfunction

  function automatic int imm_b(logic [31:0] ins);
    int v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    if (ins[31]) v -= 4096;
    return v;
  endfunction

  function automatic int imm_j(logic [31:0] ins);
    int v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    if (ins[31]) v -= 1048576;
    return v;
  endfunction

  function automatic logic [2:0] alu_of(logic [2:0] f3, logic is_sub);
    case (f3)
      3'd0: return is_sub ? 3'd1 : 3'd0;
      3'd2: return 3'd5;
      3'd4: return 3'd4;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] r);
    if (RegWriteW && RdW != 0 && RdW == r) return ResultW;
    if (r == 0) return 32'd0;
    return m_rf[r];
  endfunction

  function automatic out_t model_out();
    out_t o = '0;
    int   imm = 0;
    o.rs1  = m_instr[19:15];
    o.rs2  = m_instr[24:20];
    o.rd   = m_instr[11:7];
    o.rd1  = model_read(o.rs1);
    o.rd2  = model_read(o.rs2);
    o.pc   = m_pc;
    o.pcp4 = m_pcp4;
    case (m_instr[6:0])
      7'h03: begin o.regw = 1; o.alusrc = 1; o.rsrc = 2'b01; imm = imm_i(m_instr); end
      7'h23: begin o.memw = 1; o.alusrc = 1; imm = imm_s(m_instr); end
      7'h33: begin o.regw = 1; o.aluc = alu_of(m_instr[14:12], m_instr[30]); end
      7'h13: begin o.regw = 1; o.alusrc = 1; imm = imm_i(m_instr);
                   o.aluc = alu_of(m_instr[14:12], 1'b0); end
      7'h63: begin o.branch = 1; o.aluc = 3'd1; imm = imm_b(m_instr); end
      7'h6F: begin o.jump = 1; o.regw = 1; o.rsrc = 2'b10; imm = imm_j(m_instr); end
      default: ;
    endcase
    o.imm = 32'(imm);
    return o;
  endfunction

  function automatic out_t dut_out();
    return {RD1D, RD2D, ImmExtD, Rs1D, Rs2D, RdD, PCD, PCPlus4D,
            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD};
  endfunction

  // advance model with the inputs present at the edge, then step the DUT
  task automatic tick();
    if (rst) begin
      m_instr = NOP; m_pc = 0; m_pcp4 = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
    end else begin
      if (FlushD) begin
        m_instr = NOP; m_pc = 0; m_pcp4 = 0;
      end else if (!StallD) begin
        m_instr = InstrF; m_pc = PCF; m_pcp4 = PCPlus4F;
      end
      if (RegWriteW && RdW != 0) m_rf[RdW] = ResultW;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; StallD = 0; FlushD = 0; RegWriteW = 0; RdW = 0; ResultW = 0;
    InstrF = 32'h002081B3; PCF = 32'h40; PCPlus4F = 32'h44;
    tick();
    rst = 0;
    n_checks++; if (PCD !== 32'h0) $display("FAIL reset_pcd got=%h exp=%h", PCD, 32'h0); else n_pass++;
    n_checks++; if (PCPlus4D !== 32'h0) $display("FAIL reset_pcp4 got=%h exp=%h", PCPlus4D, 32'h0); else n_pass++;
    n_checks++; if ({Rs1D, Rs2D, RdD} !== 15'h0) $display("FAIL reset_nop_fields got=%h exp=0", {Rs1D, Rs2D, RdD}); else n_pass++;
    n_checks++; if (MemWriteD !== 1'b0) $display("FAIL reset_memwrite got=%b exp=0", MemWriteD); else n_pass++;
    n_checks++; if ({RD1D, RD2D, ImmExtD} !== 96'h0) $display("FAIL reset_rd_imm got=%h/%h/%h exp=0", RD1D, RD2D, ImmExtD); else n_pass++;
    // write x5, then reset while also writing x6: both must read back zero
    RegWriteW = 1; RdW = 5; ResultW = 32'hAA;
    tick();
    rst = 1; RdW = 6; ResultW = 32'hBB;
    tick();
    rst = 0; RegWriteW = 0; InstrF = 32'h006283B3;
    tick();
    n_checks++; if (RD1D !== 32'h0) $display("FAIL reset_clears_rf got=%h exp=%h", RD1D, 32'h0); else n_pass++;
    n_checks++; if (RD2D !== 32'h0) $display("FAIL reset_wins_write got=%h exp=%h", RD2D, 32'h0); else n_pass++;
  endtask

  task automatic test_rtype();
    RegWriteW = 1; RdW = 1; ResultW = 5;
    tick();
    RdW = 2; ResultW = 7;
    tick();
    RegWriteW = 0; RdW = 0; ResultW = 0;
    InstrF = 32'h002081B3; PCF = 32'h10; PCPlus4F = 32'h14;
    tick();
    n_checks++; if ({Rs1D, Rs2D, RdD} !== {5'd1, 5'd2, 5'd3}) $display("FAIL rtype_regs got=%0d,%0d,%0d exp=1,2,3", Rs1D, Rs2D, RdD); else n_pass++;
    n_checks++; if (RD1D !== 32'd5) $display("FAIL rtype_rd1 got=%h exp=%h", RD1D, 32'd5); else n_pass++;
    n_checks++; if (RD2D !== 32'd7) $display("FAIL rtype_rd2 got=%h exp=%h", RD2D, 32'd7); else n_pass++;
    n_checks++; if ({ALUControlD, RegWriteD, ALUSrcD} !== 5'b000_1_0) $display("FAIL rtype_ctrl got=%b exp=00010", {ALUControlD, RegWriteD, ALUSrcD}); else n_pass++;
    n_checks++; if ({PCD, PCPlus4D} !== {32'h10, 32'h14}) $display("FAIL rtype_pc got=%h/%h exp=10/14", PCD, PCPlus4D); else n_pass++;
  endtask

  task automatic test_bypass();
    RegWriteW = 1; RdW = 1; ResultW = 32'hDEADBEEF;
    #1;
    n_checks++; if (RD1D !== 32'hDEADBEEF) $display("FAIL bypass_rd1 got=%h exp=%h", RD1D, 32'hDEADBEEF); else n_pass++;
    n_checks++; if (RD2D !== 32'd7) $display("FAIL bypass_rd2_untouched got=%h exp=%h", RD2D, 32'd7); else n_pass++;
    RdW = 0; ResultW = 32'h1234; InstrF = 32'h002001B3;
    tick();
    n_checks++; if (RD1D !== 32'h0) $display("FAIL x0_no_bypass got=%h exp=%h", RD1D, 32'h0); else n_pass++;
    RegWriteW = 0;
    #1;
    n_checks++; if (RD1D !== 32'h0) $display("FAIL x0_write_dropped got=%h exp=%h", RD1D, 32'h0); else n_pass++;
  endtask

  task automatic test_stall_flush();
    InstrF = 32'h40B50533; PCF = 32'h20; PCPlus4F = 32'h24;
    tick();
    StallD = 1; InstrF = 32'h0000007F; PCF = 32'h99; PCPlus4F = 32'h9D;
    tick();
    InstrF = 32'h001000EF; PCF = 32'hA0;
    tick();
    n_checks++; if ({PCD, PCPlus4D} !== {32'h20, 32'h24}) $display("FAIL stall_pc got=%h/%h exp=20/24", PCD, PCPlus4D); else n_pass++;
    n_checks++; if ({RdD, ALUControlD, RegWriteD} !== {5'd10, 3'b001, 1'b1}) $display("FAIL stall_instr got=%0d,%b,%b exp=10,001,1", RdD, ALUControlD, RegWriteD); else n_pass++;
    FlushD = 1;
    tick();
    FlushD = 0; StallD = 0;
    n_checks++; if ({PCD, PCPlus4D} !== 64'h0) $display("FAIL flush_pc got=%h/%h exp=0/0", PCD, PCPlus4D); else n_pass++;
    n_checks++; if ({Rs1D, RdD, ImmExtD, ALUSrcD} !== 43'h1) $display("FAIL flush_nop got=%0d,%0d,%h,%b exp=0,0,0,1", Rs1D, RdD, ImmExtD, ALUSrcD); else n_pass++;
  endtask

  task automatic test_immediates();
    InstrF = 32'hFFC12283;
    tick();
    n_checks++; if ({ImmExtD, ResultSrcD, ALUSrcD} !== {32'hFFFFFFFC, 2'b01, 1'b1}) $display("FAIL imm_lw got=%h,%b,%b exp=fffffffc,01,1", ImmExtD, ResultSrcD, ALUSrcD); else n_pass++;
    InstrF = 32'hFE208CE3;
    tick();
    n_checks++; if ({ImmExtD, BranchD, ALUControlD} !== {32'hFFFFFFF8, 1'b1, 3'b001}) $display("FAIL imm_beq got=%h,%b,%b exp=fffffff8,1,001", ImmExtD, BranchD, ALUControlD); else n_pass++;
    InstrF = 32'h001000EF;
    tick();
    n_checks++; if ({ImmExtD, JumpD, ResultSrcD, RdD} !== {32'h800, 1'b1, 2'b10, 5'd1}) $display("FAIL imm_jal got=%h,%b,%b,%0d exp=800,1,10,1", ImmExtD, JumpD, ResultSrcD, RdD); else n_pass++;
    InstrF = 32'h40008093;
    tick();
    n_checks++; if ({ImmExtD, ALUControlD} !== {32'h400, 3'b000}) $display("FAIL ialu_no_sub got=%h,%b exp=400,000", ImmExtD, ALUControlD); else n_pass++;
  endtask

  task automatic test_illegal();
    InstrF = 32'h0000007F;
    tick();
    n_checks++; if ({RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD} !== 10'h0) $display("FAIL illegal_ctrl got=%b exp=0", {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD}); else n_pass++;
    n_checks++; if (ImmExtD !== 32'h0) $display("FAIL illegal_imm got=%h exp=%h", ImmExtD, 32'h0); else n_pass++;
    InstrF = 32'h002081B3;
    tick();
    n_checks++; if ({RD1D, RD2D} !== {32'd5, 32'd7}) $display("FAIL illegal_rf_kept got=%h/%h exp=5/7", RD1D, RD2D); else n_pass++;
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    int errs = 0;
    out_t exp_o, got_o;
    ops[0] = 7'h03; ops[1] = 7'h23; ops[2] = 7'h33; ops[3] = 7'h13;
    ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h00;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r = $urandom;
      int k = $urandom_range(0, 6);
      InstrF    = {r[31:7], (k == 6) ? 7'($urandom) : ops[k]};
      PCF       = $urandom & 32'hFFFF_FFFC;
      PCPlus4F  = PCF + 4;
      rst       = ($urandom_range(0, 63) == 0);
      FlushD    = ($urandom_range(0, 15) == 0);
      StallD    = ($urandom_range(0, 7) == 0);
      RegWriteW = $urandom_range(0, 1);
      RdW       = $urandom_range(0, 7);
      ResultW   = $urandom;
      tick();
      // bypass inputs for the decode cycle are the fresh ones
      RegWriteW = $urandom_range(0, 1);
      RdW       = $urandom_range(0, 7);
      ResultW   = $urandom;
      #1;
      exp_o = model_out();
      got_o = dut_out();
      n_checks++;
      if (got_o !== exp_o) begin
        errs++;
        if (errs <= 10) $display("FAIL random_cycle%0d got=%h exp=%h", c, got_o, exp_o);
      end else n_pass++;
    end
    rst = 0; FlushD = 0; StallD = 0; RegWriteW = 0;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_bypass();
    test_stall_flush();
    test_immediates();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
